ifid_hazard_ctrl: RTL and testbench
===================================

// Module: ifid_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the front of the pipeline. Merges hazard and redirect
//   requests (load-use, data-memory wait, MDU busy, branch, trap) into the stall/flush controls
//   of the IF/ID register, the PC register and the ID/EX bubble. Multi-cycle redirect
//   bubbles are sequenced by an FSM. A stall watchdog and a stall-cycle counter are included.
// PARAMETERS
//   FLUSH_CYCLES  1    cycles ifid_flush stays high per redirect (1..15)
//   MAX_STALL     255  consecutive busy-stall cycles before stall_timeout sets (1..65535)
// PORTS
//   clk               in   1   core clock
//   reset_n           in   1   async active-low reset
//   load_use_hazard   in   1   ID instr needs EX load result (combinational, from hazard detect)
//   mem_busy          in   1   data memory not ready; freeze front end
//   mdu_busy          in   1   multiply/divide in progress; freeze front end
//   branch_taken      in   1   EX resolved taken branch/jump; PC redirect this cycle
//   trap_taken        in   1   exception/interrupt/xRET redirect this cycle
//   ifid_stall        out  1   hold IF/ID register
//   ifid_flush        out  1   clear IF/ID register to NOP bubble
//   pc_stall          out  1   hold PC register
//   idex_bubble       out  1   insert NOP into ID/EX (load-use only)
//   stall_timeout     out  1   sticky: busy stall exceeded MAX_STALL
//   stall_cycle_count out  32  total cycles with ifid_stall=1, wraps at 2^32
// BEHAVIOUR
//   Reset (reset_n low, async): state=RUN, counters=0, stall_timeout=0, all control outputs=0.
//   Outputs are combinational from state and inputs (zero latency). Counters and flags are
//   registered on posedge clk.
//   States: RUN, BUSY, REDIRECT.
//   Priority each cycle: trap_taken > branch_taken > (mem_busy|mdu_busy) > load_use_hazard.
//   Redirect (trap|branch) in any state:
//     - ifid_flush=1, ifid_stall=0, pc_stall=0, idex_bubble=0.
//     - The busy counter clears.
//     - FLUSH_CYCLES==1: next state is RUN.
//     - Otherwise: next state is REDIRECT and rd_cnt loads FLUSH_CYCLES-1.
//   REDIRECT: ifid_flush=1 and rd_cnt decrements each cycle; state goes to RUN on the cycle
//     rd_cnt==1. A new redirect reloads rd_cnt (restart). In this state busy and load_use are
//     ignored for outputs. Busy is re-evaluated in RUN.
//   Busy (mem_busy|mdu_busy), no redirect: ifid_stall=1, pc_stall=1, idex_bubble=0.
//     - State goes to BUSY and busy_cnt increments (saturates at MAX_STALL).
//     - When busy_cnt reaches MAX_STALL, stall_timeout sets. It stays set until a trap_taken
//       cycle (branch does not clear it).
//     - Busy dropping returns the state to RUN and clears busy_cnt.
//   Load-use, no redirect, no busy: ifid_stall=1, pc_stall=1, idex_bubble=1 for each cycle the
//     input is high. No state change.
//   Load-use together with busy: busy rule applies, so idex_bubble=0 (EX is frozen too).
//   Invariant: ifid_flush and ifid_stall are never both 1, and idex_bubble implies pc_stall.
//   stall_cycle_count increments on every cycle ifid_stall=1 and wraps from FFFF_FFFF to 0.
//   Async reset mid-REDIRECT or mid-BUSY aborts the sequence immediately and applies reset values.
// TESTING
//   1 Reset with all inputs 0 -> all outputs 0, count 0. Then load_use 1 cycle -> ifid_stall,
//     pc_stall and idex_bubble high exactly 1 cycle, count=1.
//   2 FLUSH_CYCLES=3, branch_taken 1 cycle -> ifid_flush high 3 cycles, stall 0. A trap in
//     cycle 2 -> flush extends to 3 more cycles.
//   3 mem_busy 5 cycles with load_use also high -> ifid_stall/pc_stall 5 cycles, idex_bubble 0,
//     count=5, state returns to RUN.
//   4 MAX_STALL=4, mdu_busy 6 cycles -> stall_timeout rises after 4th stall cycle and stays
//     after busy drops. branch leaves it set; trap_taken clears it.
//   5 branch_taken and mem_busy in the same cycle -> flush=1, stall=0. busy_cnt cleared;
//     stalls resume in the next RUN cycle.
//   6 Preload count to FFFF_FFFE, stall 3 cycles -> count 0000_0001. reset_n low mid-REDIRECT
//     -> flush drops the same instant.

Source files
------------

// File: rtl/ifid_hazard_if.sv
// Hazard/redirect requests into the front-end sequencer and the stall/flush controls it returns.
// The count preload pair is a debug hook used to seed stall_cycle_count.
interface ifid_hazard_if;
    logic        load_use_hazard;
    logic        mem_busy;
    logic        mdu_busy;
    logic        branch_taken;
    logic        trap_taken;
    logic        cnt_load;
    logic [31:0] cnt_load_val;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        pc_stall;
    logic        idex_bubble;
    logic        stall_timeout;
    logic [31:0] stall_cycle_count;

    modport slave (
        input  load_use_hazard, mem_busy, mdu_busy, branch_taken, trap_taken,
        input  cnt_load, cnt_load_val,
        output ifid_stall, ifid_flush, pc_stall, idex_bubble, stall_timeout, stall_cycle_count
    );

    modport master (
        output load_use_hazard, mem_busy, mdu_busy, branch_taken, trap_taken,
        output cnt_load, cnt_load_val,
        input  ifid_stall, ifid_flush, pc_stall, idex_bubble, stall_timeout, stall_cycle_count
    );
endinterface

// File: rtl/ifid_hazard_ctrl.sv
// Front-end stall/flush sequencer: merges load-use, busy and redirect requests into IF/ID, PC
// and ID/EX controls, with a multi-cycle redirect FSM, busy watchdog and stall-cycle counter.
module ifid_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 255
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    ifid_hazard_if.slave    hz
);
    typedef enum logic [1:0] {RUN, BUSY, REDIRECT} state_t;

    localparam logic [3:0]  RD_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] MAX_BUSY = 16'(MAX_STALL);

    state_t      state_q, state_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic [15:0] busy_cnt_q, busy_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic redirect, busy;
    logic ifid_stall, ifid_flush, pc_stall, idex_bubble;

    assign redirect = hz.trap_taken | hz.branch_taken;
    assign busy     = hz.mem_busy | hz.mdu_busy;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= RUN;
            rd_cnt_q    <= '0;
            busy_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        busy_cnt_d  = busy_cnt_q;
        timeout_d   = timeout_q;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        pc_stall    = 1'b0;
        idex_bubble = 1'b0;

        if (redirect) begin
            // A redirect in any state restarts the flush sequence.
            ifid_flush = 1'b1;
            busy_cnt_d = '0;
            if (hz.trap_taken)
                timeout_d = 1'b0;
            if (FLUSH_CYCLES == 1) begin
                state_d = RUN;
            end else begin
                state_d  = REDIRECT;
                rd_cnt_d = RD_LOAD;
            end
        end else if (state_q == REDIRECT) begin
            ifid_flush = 1'b1;
            rd_cnt_d   = rd_cnt_q - 4'd1;
            if (rd_cnt_q == 4'd1)
                state_d = RUN;
        end else if (busy) begin
            // EX is frozen along with the front end, so no bubble even under load-use.
            ifid_stall = 1'b1;
            pc_stall   = 1'b1;
            state_d    = BUSY;
            if (busy_cnt_q < MAX_BUSY)
                busy_cnt_d = busy_cnt_q + 16'd1;
            if (busy_cnt_d == MAX_BUSY)
                timeout_d = 1'b1;
        end else begin
            state_d    = RUN;
            busy_cnt_d = '0;
            if (hz.load_use_hazard) begin
                ifid_stall  = 1'b1;
                pc_stall    = 1'b1;
                idex_bubble = 1'b1;
            end
        end

        if (hz.cnt_load)
            stall_cnt_d = hz.cnt_load_val;
        else if (ifid_stall)
            stall_cnt_d = stall_cnt_q + 32'd1;
        else
            stall_cnt_d = stall_cnt_q;
    end

    assign hz.ifid_stall        = ifid_stall;
    assign hz.ifid_flush        = ifid_flush;
    assign hz.pc_stall          = pc_stall;
    assign hz.idex_bubble       = idex_bubble;
    assign hz.stall_timeout     = timeout_q;
    assign hz.stall_cycle_count = stall_cnt_q;
endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Scoreboard bench for ifid_hazard_ctrl with FLUSH_CYCLES=3, MAX_STALL=4.
module tb_ifid_hazard_ctrl;
    logic clk;
    logic reset_n;

    ifid_hazard_if hz_if ();

    ifid_hazard_ctrl #(.FLUSH_CYCLES(3), .MAX_STALL(4)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .hz        (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ctl;   // {stall, flush, pc_stall, bubble, timeout}
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ctl_now();
        return {hz_if.ifid_stall, hz_if.ifid_flush, hz_if.pc_stall,
                hz_if.idex_bubble, hz_if.stall_timeout};
    endfunction

    // Outputs are combinational; sample mid-cycle on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_ctl"}, 32'(ctl_now()), 32'(e.ctl));
            check({e.tag, "_cnt"}, hz_if.stall_cycle_count, e.cnt);
            check({e.tag, "_inv"}, 32'((hz_if.ifid_flush & hz_if.ifid_stall) |
                                       (hz_if.idex_bubble & ~hz_if.pc_stall)), 32'd0);
        end
    end

    // in_v = {load_use, mem_busy, mdu_busy, branch, trap}
    task automatic step(input logic [4:0] in_v, input logic ld, input logic [4:0] ctl_exp,
                        input logic [31:0] cnt_exp, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        {hz_if.load_use_hazard, hz_if.mem_busy, hz_if.mdu_busy,
         hz_if.branch_taken, hz_if.trap_taken} = in_v;
        hz_if.cnt_load = ld;
        e.ctl = ctl_exp;
        e.cnt = cnt_exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    localparam logic [4:0] I0 = 5'b00000, LU = 5'b10000, MEM = 5'b01000, MDU = 5'b00100,
                           BR = 5'b00010, TR = 5'b00001;
    localparam logic [4:0] Z = 5'b00000, FL = 5'b01000, STB = 5'b10110, ST = 5'b10100,
                           TO = 5'b00001;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        {hz_if.load_use_hazard, hz_if.mem_busy, hz_if.mdu_busy,
         hz_if.branch_taken, hz_if.trap_taken} = I0;
        hz_if.cnt_load     = 1'b0;
        hz_if.cnt_load_val = 32'hFFFF_FFFE;
        #7;
        check("rst_ctl", 32'(ctl_now()), 32'd0);
        check("rst_cnt", hz_if.stall_cycle_count, 32'd0);
        #5 reset_n = 1'b1;

        // Load-use single cycle
        step(LU, 0, STB, 0, "lu");
        step(I0, 0, Z,   1, "lu_end");

        // Branch: 3 flush cycles; then trap in cycle 2 restarts the sequence
        step(BR, 0, FL, 1, "br1");
        step(I0, 0, FL, 1, "br2");
        step(I0, 0, FL, 1, "br3");
        step(I0, 0, Z,  1, "br_end");
        step(BR, 0, FL, 1, "br_a");
        step(TR, 0, FL, 1, "tr_b");
        step(I0, 0, FL, 1, "tr_c");
        step(I0, 0, FL, 1, "tr_d");
        step(I0, 0, Z,  1, "tr_end");

        // mem_busy with load_use: no bubble; timeout visible on 5th cycle (MAX_STALL=4)
        step(MEM | LU, 0, ST,      1, "mb1");
        step(MEM | LU, 0, ST,      2, "mb2");
        step(MEM | LU, 0, ST,      3, "mb3");
        step(MEM | LU, 0, ST,      4, "mb4");
        step(MEM | LU, 0, ST | TO, 5, "mb5");
        step(I0,       0, TO,      6, "mb_end");
        step(LU,       0, STB | TO, 6, "mb_run");
        step(TR,       0, FL | TO, 7, "mb_trap");
        step(I0,       0, FL,      7, "mb_tr2");
        step(I0,       0, FL,      7, "mb_tr3");
        step(I0,       0, Z,       7, "mb_tr_end");

        // mdu_busy 6 cycles, branch keeps timeout, trap clears it
        step(MDU, 0, ST,      7,  "md1");
        step(MDU, 0, ST,      8,  "md2");
        step(MDU, 0, ST,      9,  "md3");
        step(MDU, 0, ST,      10, "md4");
        step(MDU, 0, ST | TO, 11, "md5");
        step(MDU, 0, ST | TO, 12, "md6");
        step(I0,  0, TO,      13, "md_end");
        step(BR,  0, FL | TO, 13, "md_br");
        step(I0,  0, FL | TO, 13, "md_br2");
        step(I0,  0, FL | TO, 13, "md_br3");
        step(I0,  0, TO,      13, "md_br_end");
        step(TR,  0, FL | TO, 13, "md_tr");
        step(I0,  0, FL,      13, "md_tr2");
        step(I0,  0, FL,      13, "md_tr3");
        step(I0,  0, Z,       13, "md_tr_end");

        // Branch with mem_busy: flush wins, busy_cnt cleared, stalls resume in RUN
        step(MEM,      0, ST, 13, "bm_pre1");
        step(MEM,      0, ST, 14, "bm_pre2");
        step(MEM,      0, ST, 15, "bm_pre3");
        step(MEM | BR, 0, FL, 16, "bm_br");
        step(MEM,      0, FL, 16, "bm_rd2");
        step(MEM,      0, FL, 16, "bm_rd3");
        step(MEM,      0, ST, 16, "bm_s1");
        step(MEM,      0, ST, 17, "bm_s2");
        step(MEM,      0, ST, 18, "bm_s3");
        step(I0,       0, Z,  19, "bm_end");

        // Counter wrap from preload
        step(I0,  1, Z,  19,           "ld");
        step(MEM, 0, ST, 32'hFFFF_FFFE, "wr1");
        step(MEM, 0, ST, 32'hFFFF_FFFF, "wr2");
        step(MEM, 0, ST, 32'h0000_0000, "wr3");
        step(I0,  0, Z,  32'h0000_0001, "wr_end");

        // Async reset mid-REDIRECT drops flush immediately
        step(BR, 0, FL, 1, "ar_br");
        step(I0, 0, FL, 1, "ar_rd");
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("ar_flush", 32'(hz_if.ifid_flush), 32'd0);
        check("ar_cnt",   hz_if.stall_cycle_count, 32'd0);
        #3 reset_n = 1'b1;
        step(I0, 0, Z,   0, "ar_after");
        step(LU, 0, STB, 0, "ar_lu");

        @(posedge clk);
        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
